// File: rtl/onehot_regfile.sv
// ----------------------------------------------------------------------------
// onehot_regfile
//   Architectural register file that sits after the write-select decoder tree.
//   It takes writes through a one-hot select vector and offers two
//   combinational read ports with same-cycle write bypass. A select vector with
//   two or more bits high is refused: nothing is written and it is not
//   bypassed. Such a cycle also sets a sticky error flag and bumps a
//   saturating error counter.
//
//   NUM_REGS must be a power of two and at least 4.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous reset, active low
//   wr_sel     in   [NUM_REGS]   one-hot (or all-zero) write select
//   wr_data    in   [DATA_WIDTH] write data
//   rd_addr_a  in   [AW]         read port A address
//   rd_addr_b  in   [AW]         read port B address
//   rd_data_a  out  [DATA_WIDTH] read port A data, combinational
//   rd_data_b  out  [DATA_WIDTH] read port B data, combinational
//   sel_err    out  sticky flag, set by any multi-hot select
//   err_count  out  [8]          multi-hot cycle count, saturates at 255
// ----------------------------------------------------------------------------
module onehot_regfile #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32,
    parameter int ZERO_REG   = 31,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REGS-1:0]   wr_sel,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr_a,
    input  logic [AW-1:0]         rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  sel_err,
    output logic [7:0]            err_count
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  sel_err_q, sel_err_d;
    logic [7:0]            err_count_q, err_count_d;

    logic sel_any;
    logic sel_multi;
    logic sel_legal;

    // x & (x-1) clears the lowest set bit; anything left means two or more
    // bits were high. This is an explicit multi-hot test, independent of any
    // priority encoding of the select.
    assign sel_any   = |wr_sel;
    assign sel_multi = |(wr_sel & (wr_sel - NUM_REGS'(1)));
    assign sel_legal = sel_any & ~sel_multi;

    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (sel_legal && wr_sel[k] && (k != ZERO_REG)) begin
                regs_d[k] = wr_data;
            end
        end
    end

    always_comb begin
        sel_err_d   = sel_err_q | sel_multi;
        err_count_d = err_count_q;
        if (sel_multi && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // Reset wins over everything, including a write on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
            sel_err_q   <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
            sel_err_q   <= sel_err_d;
            err_count_q <= err_count_d;
        end
    end

    // Read ports: zero register first, then bypass of a legal write, then
    // the stored value.
    always_comb begin
        if (rd_addr_a == AW'(ZERO_REG)) begin
            rd_data_a = '0;
        end else if (sel_legal && wr_sel[rd_addr_a]) begin
            rd_data_a = wr_data;
        end else begin
            rd_data_a = regs_q[rd_addr_a];
        end
    end

    always_comb begin
        if (rd_addr_b == AW'(ZERO_REG)) begin
            rd_data_b = '0;
        end else if (sel_legal && wr_sel[rd_addr_b]) begin
            rd_data_b = wr_data;
        end else begin
            rd_data_b = regs_q[rd_addr_b];
        end
    end

    assign sel_err   = sel_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_onehot_regfile.sv
// ----------------------------------------------------------------------------
// tb_onehot_regfile
//   Directed bench for onehot_regfile. The stimulus process drives inputs just
//   after each rising edge and queues the values it expects for that cycle.
//   A monitor on the falling edge pops the entries tagged with the current
//   cycle and compares them against the DUT outputs.
// ----------------------------------------------------------------------------
module tb_onehot_regfile;

    localparam int DW = 64;
    localparam int NR = 32;
    localparam int AW = 5;

    localparam int K_RDA = 0;
    localparam int K_RDB = 1;
    localparam int K_ERR = 2;
    localparam int K_CNT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [NR-1:0] wr_sel;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;
    logic          sel_err;
    logic [7:0]    err_count;

    onehot_regfile #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ZERO_REG(31)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .sel_err   (sel_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        int            kind;
        logic [DW-1:0] exp;
        string         name;
    } sb_entry_t;

    sb_entry_t sb[$];
    int        cyc = 0;
    int        n_vec = 0;
    int        n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            sb_entry_t     e;
            logic [DW-1:0] act;
            e = sb.pop_front();
            n_vec++;
            case (e.kind)
                K_RDA:   act = rd_data_a;
                K_RDB:   act = rd_data_b;
                K_ERR:   act = {63'd0, sel_err};
                default: act = {56'd0, err_count};
            endcase
            if (e.cyc != cyc) begin
                n_err++;
                $display("FAIL %s: check missed its cycle (queued %0d, now %0d)", e.name, e.cyc, cyc);
            end else if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h, want %h (cycle %0d)", e.name, act, e.exp, cyc);
            end
        end
    end

    task automatic expect_v(input int kind, input logic [DW-1:0] v, input string nm);
        sb_entry_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.exp  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [NR-1:0] s, input logic [DW-1:0] d,
                         input logic [AW-1:0] a, input logic [AW-1:0] b);
        reset     = r;
        wr_sel    = s;
        wr_data   = d;
        rd_addr_a = a;
        rd_addr_b = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, queue depth %0d", sb.size());
        $fatal(1, "watchdog expired");
    end

    int model_cnt;

    initial begin
        drive(1'b0, '0, '0, '0, '0);
        step();
        step();

        // Reset state: every readable register is zero, error state clear.
        for (int i = 0; i <= 30; i++) begin
            drive(1'b1, '0, '0, AW'(i), AW'(30 - i));
            expect_v(K_RDA, 64'd0, $sformatf("reset_rd_a[%0d]", i));
            if (i == 0) begin
                expect_v(K_ERR, 64'd0, "reset_sel_err");
                expect_v(K_CNT, 64'd0, "reset_err_count");
            end
            step();
        end

        // Legal write to reg 5, then read it back.
        drive(1'b1, 32'h0000_0020, 64'hDEAD_BEEF_0000_0005, 5'd0, 5'd0);
        step();
        drive(1'b1, '0, 64'd0, 5'd5, 5'd4);
        expect_v(K_RDA, 64'hDEAD_BEEF_0000_0005, "legal_rd_reg5");
        expect_v(K_RDB, 64'd0, "legal_rd_reg4");
        step();

        // Same-cycle bypass on both ports.
        drive(1'b1, 32'h0000_0080, 64'h77, 5'd7, 5'd7);
        expect_v(K_RDA, 64'h77, "bypass_rd_a_reg7");
        expect_v(K_RDB, 64'h77, "bypass_rd_b_reg7");
        step();
        // Legal select of the zero register: no write, reads stay 0.
        drive(1'b1, 32'h8000_0000, 64'hFF, 5'd5, 5'd31);
        expect_v(K_RDB, 64'd0, "zero_reg_bypass_blocked");
        step();
        drive(1'b1, '0, 64'd0, 5'd7, 5'd31);
        expect_v(K_RDA, 64'h77, "reg7_stored");
        expect_v(K_RDB, 64'd0, "zero_reg_after_write");
        expect_v(K_ERR, 64'd0, "zero_reg_no_sel_err");
        step();

        // Illegal select: no bypass, no write, error flagged.
        drive(1'b1, 32'h0000_0008, 64'h33, 5'd0, 5'd0);
        step();
        drive(1'b1, 32'h0000_000C, 64'h99, 5'd3, 5'd2);
        expect_v(K_RDA, 64'h33, "illegal_no_bypass_reg3");
        expect_v(K_RDB, 64'd0, "illegal_no_bypass_reg2");
        step();
        drive(1'b1, '0, 64'd0, 5'd3, 5'd2);
        expect_v(K_RDA, 64'h33, "illegal_reg3_kept");
        expect_v(K_RDB, 64'd0, "illegal_reg2_kept");
        expect_v(K_ERR, 64'd1, "illegal_sel_err");
        expect_v(K_CNT, 64'd1, "illegal_err_count");
        step();

        // 300 further illegal cycles: counter saturates at 255.
        model_cnt = 1;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 32'hFFFF_FFFF, 64'hABCD, 5'd3, 5'd5);
            expect_v(K_CNT, 64'(model_cnt), $sformatf("sat_err_count[%0d]", i));
            step();
            if (model_cnt < 255) model_cnt++;
        end
        drive(1'b1, '0, 64'd0, 5'd3, 5'd5);
        expect_v(K_CNT, 64'd255, "sat_err_count_final");
        expect_v(K_ERR, 64'd1, "sat_sel_err");
        expect_v(K_RDA, 64'h33, "sat_reg3_kept");
        expect_v(K_RDB, 64'hDEAD_BEEF_0000_0005, "sat_reg5_kept");
        step();

        // Reset with a simultaneous legal write: reset wins.
        drive(1'b0, 32'h0000_0200, 64'h1234, 5'd9, 5'd9);
        step();
        drive(1'b1, '0, 64'd0, 5'd9, 5'd3);
        expect_v(K_RDA, 64'd0, "rst_write_reg9");
        expect_v(K_RDB, 64'd0, "rst_clears_reg3");
        expect_v(K_ERR, 64'd0, "rst_sel_err");
        expect_v(K_CNT, 64'd0, "rst_err_count");
        step();

        // Fill regs 0..30 then sweep both ports in opposite directions.
        for (int i = 0; i <= 30; i++) begin
            drive(1'b1, NR'(1) << i, 64'(i) * 64'h0101, 5'd31, 5'd31);
            step();
        end
        for (int i = 0; i <= 30; i++) begin
            drive(1'b1, '0, 64'd0, AW'(i), AW'(30 - i));
            expect_v(K_RDA, 64'(i) * 64'h0101, $sformatf("sweep_rd_a[%0d]", i));
            expect_v(K_RDB, 64'(30 - i) * 64'h0101, $sformatf("sweep_rd_b[%0d]", 30 - i));
            step();
        end

        for (int i = 0; i < 5 && sb.size() > 0; i++) step();
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d checks left unconsumed, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/onehot_regfile.md
Name: onehot_regfile

Overview:
Architectural register file for the 5-stage pipeline CPU, directly downstream of the write-select decoder tree. That tree is built from 2-to-4 decoders and produces a one-hot write-enable vector. The block stores NUM_REGS registers, accepts a write through the one-hot select, and provides two combinational read ports with same-cycle write bypass. It also detects and flags malformed (non-one-hot) select vectors.

Parameters:
DATA_WIDTH, 64, width of each register and of the data ports
NUM_REGS, 32, number of registers; must be a power of two, at least 4
ZERO_REG, 31, index of the hard-wired zero register; reads return 0 and writes are discarded

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset
wr_sel  input  NUM_REGS  write select from the decoder tree; one-hot or all-zero when legal
wr_data  input  DATA_WIDTH  write data
rd_addr_a  input  log2(NUM_REGS)  read port A address
rd_addr_b  input  log2(NUM_REGS)  read port B address
rd_data_a  output  DATA_WIDTH  read port A data, combinational
rd_data_b  output  DATA_WIDTH  read port B data, combinational
sel_err  output  1  sticky, registered flag; set when wr_sel had two or more bits high
err_count  output  8  count of cycles with an illegal wr_sel; saturates at 255

Behaviour:
- Reset is synchronous and active-low. It takes effect on any rising edge where reset=0.
  - All registers clear to 0.
  - sel_err clears to 0 and err_count clears to 0.
  - Any write presented in the same cycle is discarded.
  - Asserting reset mid-operation overrides everything else, including a simultaneous legal write.
- wr_sel classification, evaluated every cycle:
  - NONE: all bits 0.
  - LEGAL: exactly one bit set.
  - ILLEGAL: two or more bits set.
- Write, one-cycle latency:
  - On a rising edge with reset=1 and wr_sel LEGAL at bit k, with k != ZERO_REG, register k takes wr_data.
  - Bit k == ZERO_REG is a legal select but causes no write.
  - NONE causes no write.
  - ILLEGAL causes no write to any register; the register file is unchanged.
- Error tracking, registered:
  - On an ILLEGAL edge, sel_err becomes 1 and stays 1 until reset.
  - On each ILLEGAL edge, err_count increments by 1 and holds at 255 once reached; it does not wrap.
  - LEGAL and NONE cycles leave sel_err and err_count unchanged.
- Read, combinational, zero latency, evaluated independently for each port p:
  - If rd_addr_p == ZERO_REG, rd_data_p = 0.
  - Otherwise, if wr_sel is LEGAL with bit k == rd_addr_p, rd_data_p = wr_data (bypass). Write and read of the same register in the same cycle therefore return the new value.
  - Otherwise, rd_data_p = the stored register rd_addr_p.
  - Bypass never applies when wr_sel is ILLEGAL.
  - Both ports may read the same address simultaneously and return identical data.
- The reset value of rd_data_a and rd_data_b follows from the read rules: 0 for every address once reset has cleared the registers.
- No X propagation: the ILLEGAL check must be explicit (population count or equivalent), not inferred from a priority encoder.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then read rd_addr_a=0..30 -> all rd_data 0; sel_err=0; err_count=0.
- Legal write then read: wr_sel=32'h0000_0020, wr_data=64'hDEAD_BEEF_0000_0005, one edge; then rd_addr_a=5 -> rd_data_a=64'hDEAD_BEEF_0000_0005; rd_addr_b=4 -> rd_data_b=0.
- Bypass and zero register: in the same cycle, wr_sel bit 7 set, wr_data=64'h77, rd_addr_a=7 -> rd_data_a=64'h77 before the edge. Then wr_sel=32'h8000_0000, wr_data=64'hFF, edge; rd_addr_b=31 -> rd_data_b=0; sel_err=0.
- Illegal select: reg 3 holds 64'h33; wr_sel=32'h0000_000C, wr_data=64'h99, rd_addr_a=3 -> rd_data_a=64'h33 (no bypass). After the edge: reg 3 still 64'h33, reg 2 still 0, sel_err=1, err_count=1. Then 300 further consecutive ILLEGAL cycles -> err_count=255, sel_err=1.
- Reset during write: reset=0 with wr_sel bit 9 set and wr_data=64'h1234 on the same edge -> reg 9=0, sel_err=0, err_count=0 afterwards.
- Dual-port sweep: write reg i = i*64'h0101 for i=0..30 over consecutive edges, then sweep rd_addr_a=i and rd_addr_b=30-i -> rd_data_a=i*64'h0101 and rd_data_b=(30-i)*64'h0101 on every cycle.
